// File: rtl/entropy_seed_ctrl.sv
// -----------------------------------------------------------------------------
// entropy_seed_ctrl
//
// Collects bytes from an entropy source behind a start-up self test. It then
// packs pairs of clean bytes into a 16-bit seed word and offers that word
// through a wipe-on-read CSR. Repeated health-test failures lock the block
// into a sticky DEAD state, which only rst can clear.
//
// Parameters
//   BIST_BYTES    consecutive clean bytes needed to leave BIST (1..255)
//   MAX_FAIL      consecutive errored bytes that force DEAD (1..15)
//
// Ports
//   clk           single clock, rising edge
//   rst           synchronous active-high reset
//   ent_enable_o  enable to the entropy source (low only in DEAD)
//   ent_data_i    byte from the entropy source
//   ent_valid_i   one-cycle strobe, one byte per high cycle
//   ent_error_i   health flags [0] repetition, [1] adaptive proportion
//   seed_rd_i     one-cycle read strobe from the seed CSR
//   seed_o        {OPST[1:0], 14'b0, entropy[15:0]}, registered
//   dead_o        high while in DEAD
// -----------------------------------------------------------------------------
module entropy_seed_ctrl #(
   parameter int unsigned BIST_BYTES = 16,
   parameter int unsigned MAX_FAIL   = 3
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ent_enable_o,
   input  logic [7:0]  ent_data_i,
   input  logic        ent_valid_i,
   input  logic [1:0]  ent_error_i,
   input  logic        seed_rd_i,
   output logic [31:0] seed_o,
   output logic        dead_o
);

   typedef enum logic [1:0] {
      ST_BIST = 2'b00,
      ST_WAIT = 2'b01,
      ST_ES16 = 2'b10,
      ST_DEAD = 2'b11
   } state_t;

   localparam logic [7:0] BIST_LIMIT = 8'(BIST_BYTES);
   localparam logic [3:0] FAIL_LIMIT = 4'(MAX_FAIL);

   state_t      state_q,    state_d;
   logic [7:0]  bist_cnt_q, bist_cnt_d;
   logic [3:0]  fail_cnt_q, fail_cnt_d;
   logic        phase_q,    phase_d;
   logic [15:0] hold_q,     hold_d;
   logic [31:0] seed_q,     seed_d;

   logic byte_ok;
   logic byte_err;
   logic fail_inc;

   assign byte_ok  = ent_valid_i && (ent_error_i == 2'b00);
   assign byte_err = ent_valid_i && (ent_error_i != 2'b00);

   // Next-state and datapath.
   always_comb begin
      state_d    = state_q;
      bist_cnt_d = bist_cnt_q;
      fail_cnt_d = fail_cnt_q;
      phase_d    = phase_q;
      hold_d     = hold_q;
      fail_inc   = 1'b0;

      unique case (state_q)
         ST_BIST: begin
            if (byte_ok) begin
               fail_cnt_d = 4'd0;
               if (bist_cnt_q != BIST_LIMIT) begin
                  bist_cnt_d = bist_cnt_q + 8'd1;
               end
            end else if (byte_err) begin
               bist_cnt_d = 8'd0;
               fail_inc   = 1'b1;
            end
            // Exit is decided on the registered count, so WAIT appears one
            // cycle after the final clean byte has been counted.
            if (bist_cnt_q == BIST_LIMIT) begin
               state_d = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (byte_ok) begin
               fail_cnt_d = 4'd0;
               if (!phase_q) begin
                  hold_d[15:8] = ent_data_i;
                  phase_d      = 1'b1;
               end else begin
                  hold_d[7:0]  = ent_data_i;
                  phase_d      = 1'b0;
                  state_d      = ST_ES16;
               end
            end else if (byte_err) begin
               // A failed byte poisons any half-built word.
               phase_d  = 1'b0;
               hold_d   = 16'h0000;
               fail_inc = 1'b1;
            end
         end

         ST_ES16: begin
            // Incoming bytes and health flags are dropped while a word is
            // waiting to be read; a read wipes the word.
            if (seed_rd_i) begin
               state_d = ST_WAIT;
               hold_d  = 16'h0000;
               phase_d = 1'b0;
            end
         end

         ST_DEAD: begin
            hold_d  = 16'h0000;
            phase_d = 1'b0;
         end

         default: begin
            state_d = ST_DEAD;
         end
      endcase

      // Saturating failure counter; reaching the limit locks the block.
      if (fail_inc) begin
         if (fail_cnt_q >= FAIL_LIMIT - 4'd1) begin
            fail_cnt_d = FAIL_LIMIT;
            state_d    = ST_DEAD;
            hold_d     = 16'h0000;
            phase_d    = 1'b0;
         end else begin
            fail_cnt_d = fail_cnt_q + 4'd1;
         end
      end

      // The CSR image is built from next-state values and registered, so
      // seed_o has no combinational path from any input.
      seed_d = {state_d, 14'b0, (state_d == ST_ES16) ? hold_d : 16'h0000};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_BIST;
         bist_cnt_q <= 8'd0;
         fail_cnt_q <= 4'd0;
         phase_q    <= 1'b0;
         hold_q     <= 16'h0000;
         seed_q     <= 32'h0000_0000;
      end else begin
         state_q    <= state_d;
         bist_cnt_q <= bist_cnt_d;
         fail_cnt_q <= fail_cnt_d;
         phase_q    <= phase_d;
         hold_q     <= hold_d;
         seed_q     <= seed_d;
      end
   end

   assign seed_o       = seed_q;
   assign dead_o       = (state_q == ST_DEAD);
   assign ent_enable_o = (state_q != ST_DEAD);

endmodule

// File: tb/tb_entropy_seed_ctrl.sv
module tb_entropy_seed_ctrl;

   localparam int N_BIST = 16;
   localparam int N_FAIL = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ent_enable_o;
   logic [7:0]  ent_data_i = 8'h00;
   logic        ent_valid_i = 1'b0;
   logic [1:0]  ent_error_i = 2'b00;
   logic        seed_rd_i = 1'b0;
   logic [31:0] seed_o;
   logic        dead_o;

   int checks = 0;
   int errors = 0;

   // Reference model: mode numbers follow the OPST encoding.
   int          m_mode = 0;
   int          m_bist = 0;
   int          m_fail = 0;
   logic [7:0]  m_q[$];
   logic [15:0] m_word = 16'h0000;

   entropy_seed_ctrl #(.BIST_BYTES(N_BIST), .MAX_FAIL(N_FAIL)) dut (
      .clk          (clk),
      .rst          (rst),
      .ent_enable_o (ent_enable_o),
      .ent_data_i   (ent_data_i),
      .ent_valid_i  (ent_valid_i),
      .ent_error_i  (ent_error_i),
      .seed_rd_i    (seed_rd_i),
      .seed_o       (seed_o),
      .dead_o       (dead_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input logic r, input logic v, input logic [7:0] d,
                             input logic [1:0] e, input logic rd);
      bit ok;
      bit bad;
      int bist_old;
      ok  = v && (e == 2'b00);
      bad = v && (e != 2'b00);
      if (r) begin
         m_mode = 0; m_bist = 0; m_fail = 0; m_q.delete(); m_word = 16'h0000;
      end else if (m_mode != 3) begin
         if (m_mode == 0) begin
            bist_old = m_bist;
            if (ok) begin
               m_fail = 0;
               if (m_bist < N_BIST) m_bist++;
            end else if (bad) begin
               m_bist = 0;
               m_fail++;
            end
            if (bist_old >= N_BIST) m_mode = 1;
         end else if (m_mode == 1) begin
            if (ok) begin
               m_fail = 0;
               m_q.push_back(d);
               if (m_q.size() == 2) begin
                  m_word = {m_q[0], m_q[1]};
                  m_q.delete();
                  m_mode = 2;
               end
            end else if (bad) begin
               m_q.delete();
               m_word = 16'h0000;
               m_fail++;
            end
         end else begin
            if (rd) begin
               m_mode = 1;
               m_word = 16'h0000;
            end
         end
         if (m_fail >= N_FAIL) begin
            m_fail = N_FAIL;
            m_mode = 3;
            m_word = 16'h0000;
            m_q.delete();
         end
      end
   endtask

   // One clock cycle: drive, model, then compare one time unit after the edge.
   task automatic cyc(input logic r, input logic v, input logic [7:0] d,
                      input logic [1:0] e, input logic rd);
      logic [31:0] exp_seed;
      logic [1:0]  opst;
      rst = r; ent_valid_i = v; ent_data_i = d; ent_error_i = e; seed_rd_i = rd;
      @(posedge clk);
      model_step(r, v, d, e, rd);
      #1;
      opst     = 2'(m_mode);
      exp_seed = {opst, 14'b0, (m_mode == 2) ? m_word : 16'h0000};
      chk("seed_o", seed_o, exp_seed);
      chk("dead_o", {31'b0, dead_o}, {31'b0, (m_mode == 3)});
      chk("ent_enable_o", {31'b0, ent_enable_o}, {31'b0, (m_mode != 3)});
      if (r || v || rd)
         $display("txn t=%0t rst=%b valid=%b data=%h err=%b rd=%b seed=%h dead=%b",
                  $time, r, v, d, e, rd, seed_o, dead_o);
   endtask

   task automatic byte_ok(input logic [7:0] d);
      cyc(1'b0, 1'b1, d, 2'b00, 1'b0);
   endtask

   task automatic byte_bad(input logic [1:0] e);
      cyc(1'b0, 1'b1, 8'h5A, e, 1'b0);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
      cyc(1'b1, 1'b1, 8'hEE, 2'b00, 1'b1);
   endtask

   task automatic pass_bist();
      for (int i = 0; i < N_BIST; i++) byte_ok(8'(i));
      chk("bist_last_still_00", seed_o, 32'h0000_0000);
      idle();
      chk("bist_exit_wait", seed_o, 32'h4000_0000);
   endtask

   initial begin
      // Reset state
      do_reset();
      chk("reset_seed", seed_o, 32'h0000_0000);
      chk("reset_dead", {31'b0, dead_o}, 32'h0);
      chk("reset_enable", {31'b0, ent_enable_o}, 32'h1);

      // BIST exit, then first word and wipe-on-read
      pass_bist();
      byte_ok(8'hA5);
      byte_ok(8'h3C);
      chk("word_a53c", seed_o, 32'h8000_A53C);
      cyc(1'b0, 1'b0, 8'h00, 2'b00, 1'b1);
      chk("wipe_on_read", seed_o, 32'h4000_0000);

      // Errored byte discards a partial half
      byte_ok(8'h11);
      chk("partial_hidden", seed_o, 32'h4000_0000);
      byte_bad(2'b01);
      byte_ok(8'h22);
      byte_ok(8'h33);
      chk("word_2233", seed_o, 32'h8000_2233);
      cyc(1'b0, 1'b0, 8'h00, 2'b00, 1'b1);

      // Clean byte clears the failure count
      byte_bad(2'b01);
      byte_bad(2'b10);
      byte_ok(8'h44);
      byte_bad(2'b11);
      byte_bad(2'b01);
      chk("no_dead_after_clear", {31'b0, dead_o}, 32'h0);
      byte_ok(8'hAA);
      byte_ok(8'hBB);
      chk("word_aabb", seed_o, 32'h8000_AABB);

      // Read and byte together in ES16: read wins, byte dropped
      cyc(1'b0, 1'b1, 8'hFF, 2'b00, 1'b1);
      chk("read_beats_byte", seed_o, 32'h4000_0000);
      byte_ok(8'h01);
      byte_ok(8'h02);
      chk("word_0102", seed_o, 32'h8000_0102);

      // ES16 ignores errors; read coinciding with second WAIT byte
      byte_bad(2'b11);
      byte_bad(2'b11);
      byte_bad(2'b11);
      chk("es16_ignores_errors", seed_o, 32'h8000_0102);
      cyc(1'b0, 1'b0, 8'h00, 2'b00, 1'b1);
      byte_ok(8'h10);
      chk("read_sees_wait", seed_o, 32'h4000_0000);
      cyc(1'b0, 1'b1, 8'h20, 2'b00, 1'b1);
      chk("es16_after_coincide", seed_o, 32'h8000_1020);
      cyc(1'b0, 1'b0, 8'h00, 2'b00, 1'b1);

      // DEAD from WAIT, sticky until reset
      byte_bad(2'b01);
      byte_bad(2'b01);
      byte_bad(2'b10);
      chk("dead_wait_seed", seed_o, 32'hC000_0000);
      chk("dead_wait_flag", {31'b0, dead_o}, 32'h1);
      chk("dead_wait_enable", {31'b0, ent_enable_o}, 32'h0);
      byte_ok(8'h77);
      byte_ok(8'h88);
      cyc(1'b0, 1'b1, 8'h99, 2'b00, 1'b1);
      chk("dead_sticky", seed_o, 32'hC000_0000);

      // DEAD from BIST
      do_reset();
      chk("reset_from_dead", seed_o, 32'h0000_0000);
      byte_ok(8'h01);
      byte_bad(2'b01);
      byte_bad(2'b01);
      byte_bad(2'b01);
      chk("dead_bist_seed", seed_o, 32'hC000_0000);

      // Reset in the middle of a word
      do_reset();
      pass_bist();
      byte_ok(8'hDE);
      cyc(1'b1, 1'b1, 8'hAD, 2'b00, 1'b0);
      chk("reset_mid_word", seed_o, 32'h0000_0000);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         logic       r, v, rd;
         logic [1:0] e;
         r  = ($urandom_range(0, 249) == 0);
         v  = ($urandom_range(0, 1) == 1);
         e  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         rd = ($urandom_range(0, 5) == 0);
         cyc(r, v, 8'($urandom), e, rd);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/entropy_seed_ctrl.md
ENTROPY_SEED_CTRL -- requirements
Module: entropy_seed_ctrl

Interface
REQ-001 SHALL have parameter BIST_BYTES, default 16: consecutive error-free bytes required to leave BIST (range 1..255).
REQ-002 SHALL have parameter MAX_FAIL, default 3: consecutive errored bytes that force DEAD (range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ent_enable_o  output  1  enable to the entropy source.
REQ-006 SHALL have port ent_data_i  input  8  byte from the entropy source.
REQ-007 SHALL have port ent_valid_i  input  1  one-cycle pulse; each cycle high delivers one byte.
REQ-008 SHALL have port ent_error_i  input  2  health-test flags ([0] repetition, [1] adaptive proportion) qualifying the byte.
REQ-009 SHALL have port seed_rd_i  input  1  one-cycle read strobe from the seed CSR.
REQ-010 SHALL have port seed_o  output  32  seed CSR value: [31:30] OPST, [29:16] zero, [15:0] entropy.
REQ-011 SHALL have port dead_o  output  1  high when state is DEAD.

Function
REQ-012 SHALL implement states BIST, WAIT, ES16 and DEAD, encoded in OPST as 00, 01, 10 and 11.
REQ-013 SHALL treat a byte as accepted when ent_valid_i=1 and ent_error_i=00, and as errored when ent_valid_i=1 and ent_error_i!=00.
REQ-014 SHALL drive ent_enable_o=1 in BIST, WAIT and ES16, and 0 in DEAD.
REQ-015 In BIST, SHALL increment bist_cnt per accepted byte, discard the byte value, and move to WAIT in the cycle after bist_cnt reaches BIST_BYTES.
REQ-016 In BIST, an errored byte SHALL clear bist_cnt to 0 and increment fail_cnt.
REQ-017 In WAIT, the first accepted byte SHALL load the internal holding register bits [15:8] and set a phase bit.
REQ-018 In WAIT, the second accepted byte SHALL load holding bits [7:0], clear the phase bit, and move to ES16 in the next cycle.
REQ-019 In WAIT, an errored byte SHALL clear the phase bit and holding register, discarding any partial half, and increment fail_cnt.
REQ-020 Any accepted byte SHALL clear fail_cnt to 0.
REQ-021 When fail_cnt would reach MAX_FAIL, the block SHALL enter DEAD in the next cycle from any state.
REQ-022 DEAD SHALL be sticky until rst; in DEAD, bytes and reads SHALL be ignored and the holding register SHALL stay 0.
REQ-023 In ES16, the block SHALL ignore valid bytes, drop them without touching fail_cnt, and SHALL ignore ent_error_i.
REQ-024 seed_o SHALL be registered, reflecting state and holding register as of the previous edge, with zero combinational path from inputs.
REQ-025 seed_o[15:0] SHALL equal the holding register only in ES16, and 0 otherwise.
REQ-026 In ES16, seed_rd_i=1 SHALL move to WAIT and clear the holding register (wipe-on-read), so that the next-cycle seed_o reads {01, 14'b0, 16'b0}.
REQ-027 seed_rd_i in BIST or WAIT SHALL have no effect on state or counters.
REQ-028 If seed_rd_i and ent_valid_i are both 1 in ES16, the read SHALL be honoured and the byte dropped.
REQ-029 If the second WAIT byte and seed_rd_i coincide, the read SHALL return WAIT with zero entropy, and ES16 SHALL follow next cycle.
REQ-030 bist_cnt SHALL saturate at BIST_BYTES, and fail_cnt SHALL saturate at MAX_FAIL, with no wrap.

Reset
REQ-031 On rst=1 at a clock edge: state=BIST; bist_cnt, fail_cnt, phase and holding register = 0.
REQ-032 On rst=1 at a clock edge: seed_o=32'h0000_0000, dead_o=0, ent_enable_o=1 from the first cycle after reset release.
REQ-033 rst SHALL override every other input in the same cycle, including mid-word, in ES16 and in DEAD.

Verification
REQ-034 Reset, then 16 clean bytes -> OPST 00 until the cycle after the 16th byte, then 01; seed_o[15:0]=0.
REQ-035 After BIST, bytes 8'hA5 and 8'h3C clean -> seed_o=32'h8000_A53C; pulse seed_rd_i -> next cycle seed_o=32'h4000_0000.
REQ-036 In WAIT, send 8'h11 clean, then an errored byte (error=01), then 8'h22 and 8'h33 clean -> seed_o=32'h8000_2233, with 8'h11 never visible.
REQ-037 Three consecutive errored bytes, in BIST or WAIT -> OPST 11, dead_o=1, ent_enable_o=0; further clean bytes and reads leave seed_o=32'hC000_0000 until rst.
REQ-038 Two errored bytes, one clean byte, two errored bytes -> no DEAD, confirming fail_cnt cleared by the clean byte.
REQ-039 In ES16, send 8'hFF with seed_rd_i in the same cycle -> read completes, state WAIT, byte dropped; next two bytes 8'h01, 8'h02 -> seed_o=32'h8000_0102.
